// File: rtl/ram_port_arbiter_pkg.sv
// Shared types, default parameters and the fixed-priority/round-robin grant
// decision for the RAM command port arbiter.
package ram_arbiter_pkg;

    localparam int DEFAULT_REFRESH_INTERVAL = 780;
    localparam int DEFAULT_MAX_PENDING      = 8;
    localparam int DEFAULT_URGENT_LEVEL     = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE_BUS,
        ISSUE_VIDEO,
        ISSUE_REFRESH
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_BUS,
        GRANT_VIDEO,
        GRANT_REFRESH
    } grant_t;

    // last_bus = 1 means the previous bus/video grant went to the bus.
    function automatic grant_t arbitrate(input logic urgent, input logic bus_req,
                                         input logic video_req, input logic last_bus,
                                         input logic any_pending);
        grant_t g;
        g = GRANT_NONE;
        if (urgent)                    g = GRANT_REFRESH;
        else if (bus_req && video_req) g = last_bus ? GRANT_VIDEO : GRANT_BUS;
        else if (bus_req)              g = GRANT_BUS;
        else if (video_req)            g = GRANT_VIDEO;
        else if (any_pending)          g = GRANT_REFRESH;
        return g;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus, video and RAM-controller signals of the arbiter; slave is the
// arbiter side, master is the side of the bus/video/controller agents.
interface ram_port_arbiter_if;
    logic [19:0] address;
    logic [7:0]  internal_data_bus;
    logic        memory_read_n;
    logic        memory_write_n;
    logic        ram_address_select_n;
    logic [7:0]  data_bus_out;
    logic        memory_access_ready;
    logic        video_request;
    logic [19:0] video_address;
    logic        video_acknowledge;
    logic [7:0]  video_read_data;
    logic        ctl_request;
    logic        ctl_write;
    logic        ctl_refresh;
    logic [19:0] ctl_address;
    logic [7:0]  ctl_write_data;
    logic        ctl_acknowledge;
    logic [7:0]  ctl_read_data;
    logic [3:0]  refresh_pending;

    modport slave (
        input  address, internal_data_bus, memory_read_n, memory_write_n,
               ram_address_select_n, video_request, video_address,
               ctl_acknowledge, ctl_read_data,
        output data_bus_out, memory_access_ready, video_acknowledge,
               video_read_data, ctl_request, ctl_write, ctl_refresh,
               ctl_address, ctl_write_data, refresh_pending
    );

    modport master (
        output address, internal_data_bus, memory_read_n, memory_write_n,
               ram_address_select_n, video_request, video_address,
               ctl_acknowledge, ctl_read_data,
        input  data_bus_out, memory_access_ready, video_acknowledge,
               video_read_data, ctl_request, ctl_write, ctl_refresh,
               ctl_address, ctl_write_data, refresh_pending
    );
endinterface

// File: rtl/ram_port_arbiter_refresh_scheduler.sv
// Free-running refresh interval timer and saturating count of owed refreshes.
module refresh_scheduler
    import ram_arbiter_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEFAULT_MAX_PENDING,
    parameter int URGENT_LEVEL     = DEFAULT_URGENT_LEVEL
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       refresh_done_i,
    output logic [3:0] pending_o,
    output logic       urgent_o,
    output logic       any_o
);

    localparam int CW = $clog2(REFRESH_INTERVAL);

    logic [CW-1:0] interval_q;
    logic [3:0]    pending_q;
    logic [3:0]    pending_d;
    logic          wrap;

    assign wrap = (interval_q == CW'(REFRESH_INTERVAL - 1));

    // A credit and a completion in the same cycle cancel out.
    always_comb begin
        pending_d = pending_q;
        if (wrap && !refresh_done_i) begin
            if (pending_q < 4'(MAX_PENDING))
                pending_d = pending_q + 4'd1;
        end else if (!wrap && refresh_done_i && pending_q != 4'd0) begin
            pending_d = pending_q - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            interval_q <= '0;
            pending_q  <= '0;
        end else begin
            interval_q <= wrap ? '0 : interval_q + 1'b1;
            pending_q  <= pending_d;
        end
    end

    assign pending_o = pending_q;
    assign urgent_o  = (pending_q >= 4'(URGENT_LEVEL));
    assign any_o     = (pending_q != 4'd0);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single RAM controller command port between bus cycles, video
// fetches and refresh; holds the bus in wait states until its access completes.
module ram_port_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEFAULT_MAX_PENDING,
    parameter int URGENT_LEVEL     = DEFAULT_URGENT_LEVEL
) (
    input  logic              clock,
    input  logic              reset_n,
    ram_port_arbiter_if.slave port_if
);

    state_t      state_q;
    logic        last_bus_q;
    logic        bus_done_q;
    logic        bus_abort_q;
    logic        ctl_request_q;
    logic        ctl_write_q;
    logic        ctl_refresh_q;
    logic [19:0] ctl_address_q;
    logic [7:0]  ctl_write_data_q;
    logic [7:0]  data_bus_out_q;
    logic        video_ack_q;
    logic [7:0]  video_data_q;

    logic        bus_active;
    logic        bus_req;
    logic        refresh_done;
    logic        refresh_urgent;
    logic        refresh_any;
    grant_t      grant;

    // Both strobes low at once is not a valid cycle and is treated as idle.
    assign bus_active   = ~port_if.ram_address_select_n &
                          ((~port_if.memory_read_n) ^ (~port_if.memory_write_n));
    assign bus_req      = bus_active & ~bus_done_q;
    assign grant        = arbitrate(refresh_urgent, bus_req, port_if.video_request,
                                    last_bus_q, refresh_any);
    assign refresh_done = (state_q == ISSUE_REFRESH) & port_if.ctl_acknowledge;

    refresh_scheduler #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .MAX_PENDING      (MAX_PENDING),
        .URGENT_LEVEL     (URGENT_LEVEL)
    ) u_refresh (
        .clock          (clock),
        .reset_n        (reset_n),
        .refresh_done_i (refresh_done),
        .pending_o      (port_if.refresh_pending),
        .urgent_o       (refresh_urgent),
        .any_o          (refresh_any)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            last_bus_q       <= 1'b0;
            bus_done_q       <= 1'b0;
            bus_abort_q      <= 1'b0;
            ctl_request_q    <= 1'b0;
            ctl_write_q      <= 1'b0;
            ctl_refresh_q    <= 1'b0;
            ctl_address_q    <= '0;
            ctl_write_data_q <= '0;
            data_bus_out_q   <= '0;
            video_ack_q      <= 1'b0;
            video_data_q     <= '0;
        end else begin
            video_ack_q <= 1'b0;
            if (!bus_active)
                bus_done_q <= 1'b0;
            if (state_q == ISSUE_BUS && !bus_active)
                bus_abort_q <= 1'b1;

            if (state_q == IDLE) begin
                case (grant)
                    GRANT_BUS: begin
                        state_q          <= ISSUE_BUS;
                        ctl_request_q    <= 1'b1;
                        ctl_write_q      <= ~port_if.memory_write_n;
                        ctl_refresh_q    <= 1'b0;
                        ctl_address_q    <= port_if.address;
                        ctl_write_data_q <= port_if.internal_data_bus;
                        last_bus_q       <= 1'b1;
                        bus_abort_q      <= 1'b0;
                    end
                    GRANT_VIDEO: begin
                        state_q          <= ISSUE_VIDEO;
                        ctl_request_q    <= 1'b1;
                        ctl_write_q      <= 1'b0;
                        ctl_refresh_q    <= 1'b0;
                        ctl_address_q    <= port_if.video_address;
                        ctl_write_data_q <= '0;
                        last_bus_q       <= 1'b0;
                    end
                    GRANT_REFRESH: begin
                        state_q          <= ISSUE_REFRESH;
                        ctl_request_q    <= 1'b1;
                        ctl_write_q      <= 1'b0;
                        ctl_refresh_q    <= 1'b1;
                        ctl_address_q    <= '0;
                        ctl_write_data_q <= '0;
                    end
                    default: ;
                endcase
            end else if (port_if.ctl_acknowledge) begin
                state_q       <= IDLE;
                ctl_request_q <= 1'b0;
                ctl_write_q   <= 1'b0;
                ctl_refresh_q <= 1'b0;
                // An abandoned bus cycle still completes but must not release
                // a later access or overwrite the held read data.
                if (state_q == ISSUE_BUS && bus_active && !bus_abort_q) begin
                    bus_done_q <= 1'b1;
                    if (!ctl_write_q)
                        data_bus_out_q <= port_if.ctl_read_data;
                end
                if (state_q == ISSUE_VIDEO) begin
                    video_ack_q  <= 1'b1;
                    video_data_q <= port_if.ctl_read_data;
                end
            end
        end
    end

    assign port_if.memory_access_ready = ~bus_req;
    assign port_if.ctl_request         = ctl_request_q;
    assign port_if.ctl_write           = ctl_write_q;
    assign port_if.ctl_refresh         = ctl_refresh_q;
    assign port_if.ctl_address         = ctl_address_q;
    assign port_if.ctl_write_data      = ctl_write_data_q;
    assign port_if.data_bus_out        = data_bus_out_q;
    assign port_if.video_acknowledge   = video_ack_q;
    assign port_if.video_read_data     = video_data_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scenario bench for ram_port_arbiter: a RAM controller model answers
// commands, a monitor logs every issued command into a scoreboard queue.
module tb_ram_port_arbiter;
    import ram_arbiter_pkg::*;

    localparam int RI = DEFAULT_REFRESH_INTERVAL;
    localparam logic [52:0] RESET_VEC = 53'd1;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    ram_port_arbiter_if pif ();

    ram_port_arbiter #(
        .REFRESH_INTERVAL (RI),
        .MAX_PENDING      (8),
        .URGENT_LEVEL     (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .port_if (pif)
    );

    logic [29:0] exp_q[$];
    logic [29:0] obs_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          lat = 3;
    bit          hold_refresh = 1'b0;
    logic [7:0]  resp_data = 8'hA5;
    int          video_pulses = 0;
    bit          video_long = 1'b0;

    function automatic logic [29:0] pack_cmd(input logic r, input logic w,
                                             input logic [19:0] a, input logic [7:0] d);
        if (r) return {2'b10, 28'd0};
        if (!w) return {2'b00, a, 8'd0};
        return {2'b01, a, d};
    endfunction

    function automatic logic [52:0] outputs_now();
        return {pif.ctl_request, pif.ctl_write, pif.ctl_refresh, pif.ctl_address,
                pif.ctl_write_data, pif.data_bus_out, pif.video_acknowledge,
                pif.video_read_data, pif.refresh_pending, pif.memory_access_ready};
    endfunction

    task automatic bus_drive(input bit wr, input logic [19:0] a, input logic [7:0] d);
        pif.address              = a;
        pif.internal_data_bus    = d;
        pif.memory_read_n        = wr;
        pif.memory_write_n       = !wr;
        pif.ram_address_select_n = 1'b0;
    endtask

    task automatic bus_release();
        pif.memory_read_n        = 1'b1;
        pif.memory_write_n       = 1'b1;
        pif.ram_address_select_n = 1'b1;
    endtask

    // RAM controller model: acks each accepted command lat cycles after request.
    initial begin
        int cnt;
        bit busy;
        busy = 1'b0;
        cnt  = 0;
        pif.ctl_acknowledge = 1'b0;
        pif.ctl_read_data   = 8'h00;
        forever begin
            @(posedge clock); #1;
            pif.ctl_acknowledge = 1'b0;
            if (!reset_n) begin
                busy = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt <= 0) begin
                    pif.ctl_acknowledge = 1'b1;
                    pif.ctl_read_data   = resp_data;
                    busy = 1'b0;
                end
            end else if (pif.ctl_request === 1'b1 && !(hold_refresh && pif.ctl_refresh)) begin
                busy = 1'b1;
                cnt  = lat - 1;
            end
        end
    end

    // Command monitor: one line per issued command.
    initial begin
        bit prev_req, prev_vack;
        prev_req  = 1'b0;
        prev_vack = 1'b0;
        forever begin
            @(negedge clock);
            if (pif.ctl_request === 1'b1 && !prev_req) begin
                obs_q.push_back(pack_cmd(pif.ctl_refresh, pif.ctl_write,
                                         pif.ctl_address, pif.ctl_write_data));
                $display("[%0t] cmd refresh=%0b write=%0b addr=%05h data=%02h pending=%0d",
                         $time, pif.ctl_refresh, pif.ctl_write, pif.ctl_address,
                         pif.ctl_write_data, pif.refresh_pending);
            end
            prev_req = (pif.ctl_request === 1'b1);
            if (pif.video_acknowledge === 1'b1) begin
                video_pulses++;
                if (prev_vack) video_long = 1'b1;
            end
            prev_vack = (pif.video_acknowledge === 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        compared++;
        if (outputs_now() !== RESET_VEC) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h want %h", outputs_now(), RESET_VEC);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_bus_read();
        int n;
        bit bad;
        logic [29:0] e, o;
        // Both strobes low is not an access.
        pif.ram_address_select_n = 1'b0;
        pif.memory_read_n = 1'b0;
        pif.memory_write_n = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (pif.memory_access_ready !== 1'b1 || pif.ctl_request !== 1'b0) bad = 1'b1;
        end
        compared++;
        if (bad) begin mismatched++; $display("FAIL both_strobes_ignored: got active want idle"); end
        bus_release();
        @(negedge clock);

        resp_data = 8'hA5;
        bus_drive(1'b0, 20'h12345, 8'h00);
        exp_q.push_back(pack_cmd(1'b0, 1'b0, 20'h12345, 8'h00));
        #1;
        compared++;
        if (pif.memory_access_ready !== 1'b0) begin
            mismatched++; $display("FAIL read_ready_low: got %b want 0", pif.memory_access_ready);
        end
        @(posedge clock); #1;
        compared++;
        if ({pif.ctl_request, pif.ctl_write, pif.ctl_address} !== {2'b10, 20'h12345}) begin
            mismatched++;
            $display("FAIL read_issue: got req=%b wr=%b addr=%h want req=1 wr=0 addr=12345",
                     pif.ctl_request, pif.ctl_write, pif.ctl_address);
        end
        n = 0;
        do begin @(negedge clock); n++; end while (pif.ctl_acknowledge !== 1'b1 && n < 50);
        compared++;
        if (pif.memory_access_ready !== 1'b0 || n >= 50) begin
            mismatched++; $display("FAIL read_ack_cycle_ready: got %b want 0 (n=%0d)", pif.memory_access_ready, n);
        end
        @(negedge clock);
        compared++;
        if ({pif.memory_access_ready, pif.data_bus_out} !== {1'b1, 8'hA5}) begin
            mismatched++;
            $display("FAIL read_done: got ready=%b data=%h want ready=1 data=a5",
                     pif.memory_access_ready, pif.data_bus_out);
        end
        bad = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (pif.memory_access_ready !== 1'b1 || pif.ctl_request !== 1'b0) bad = 1'b1;
        end
        compared++;
        if (bad) begin mismatched++; $display("FAIL read_ready_held: got reissue/wait want ready held"); end
        bus_release();
        repeat (2) @(negedge clock);
        compared++;
        if (obs_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL read_cmd_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL read_cmd: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_round_robin();
        int n, p0;
        logic [29:0] e, o;
        p0 = video_pulses;
        resp_data = 8'h5E;
        pif.video_address = 20'h0ABCD;
        pif.video_request = 1'b1;
        exp_q.push_back(pack_cmd(1'b0, 1'b0, 20'h0ABCD, 8'h00));
        n = 0;
        do begin @(negedge clock); n++; end while (pif.video_acknowledge !== 1'b1 && n < 100);
        pif.video_request = 1'b0;
        compared++;
        if (pif.video_read_data !== 8'h5E || n >= 100) begin
            mismatched++; $display("FAIL video_only_data: got %h want 5e (n=%0d)", pif.video_read_data, n);
        end

        @(negedge clock);
        bus_drive(1'b1, 20'h00100, 8'h3C);
        pif.video_address = 20'h0BEEF;
        pif.video_request = 1'b1;
        exp_q.push_back(pack_cmd(1'b0, 1'b1, 20'h00100, 8'h3C));
        exp_q.push_back(pack_cmd(1'b0, 1'b0, 20'h0BEEF, 8'h00));
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin @(negedge clock); n++; end while (pif.memory_access_ready !== 1'b1 && n < 100);
            bus_release();
            compared++;
            if (n >= 100) begin mismatched++; $display("FAIL rr_bus_done_%0d: got timeout want ready", k); end
            n = 0;
            do begin @(negedge clock); n++; end while (pif.video_acknowledge !== 1'b1 && n < 100);
            compared++;
            if (pif.video_read_data !== 8'h5E || n >= 100) begin
                mismatched++; $display("FAIL rr_video_data_%0d: got %h want 5e", k, pif.video_read_data);
            end
            if (k == 0) begin
                bus_drive(1'b1, 20'h00101, 8'hC3);
                pif.video_address = 20'h0BEF0;
                exp_q.push_back(pack_cmd(1'b0, 1'b1, 20'h00101, 8'hC3));
                exp_q.push_back(pack_cmd(1'b0, 1'b0, 20'h0BEF0, 8'h00));
            end else begin
                pif.video_request = 1'b0;
            end
        end
        repeat (4) @(negedge clock);
        compared++;
        if (video_pulses - p0 != 3 || video_long) begin
            mismatched++;
            $display("FAIL rr_video_pulses: got %0d (long=%0b) want 3 (long=0)", video_pulses - p0, video_long);
        end
        compared++;
        if (obs_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL rr_cmd_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL rr_cmd: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_refresh_backlog();
        int n;
        int trace[$];
        int want[5] = '{4, 3, 2, 1, 0};
        bit strobe_on;
        logic [7:0] data_seen;
        logic [29:0] e, o;
        obs_q.delete();
        hold_refresh = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (pif.refresh_pending !== 4'd4 && n < 5 * RI);
        compared++;
        if (n >= 5 * RI) begin mismatched++; $display("FAIL backlog_reach4: got %0d want 4", pif.refresh_pending); end
        exp_q.push_back(pack_cmd(1'b1, 1'b0, 20'h0, 8'h0));
        resp_data = 8'h69;
        bus_drive(1'b0, 20'h54321, 8'h00);
        strobe_on = 1'b1;
        exp_q.push_back(pack_cmd(1'b0, 1'b0, 20'h54321, 8'h00));
        repeat (3) exp_q.push_back(pack_cmd(1'b1, 1'b0, 20'h0, 8'h0));
        trace.push_back(int'(pif.refresh_pending));
        hold_refresh = 1'b0;
        data_seen = 8'h00;
        n = 0;
        do begin
            @(negedge clock); n++;
            if (int'(pif.refresh_pending) != trace[$]) trace.push_back(int'(pif.refresh_pending));
            if (strobe_on && pif.memory_access_ready === 1'b1) begin
                data_seen = pif.data_bus_out;
                bus_release();
                strobe_on = 1'b0;
            end
        end while (!(pif.refresh_pending === 4'd0 && !strobe_on && pif.ctl_request === 1'b0) && n < 300);
        compared++;
        if (trace.size() != 5) begin mismatched++; $display("FAIL backlog_trace_len: got %0d want 5", trace.size()); end
        for (int i = 0; i < 5 && i < trace.size(); i++) begin
            compared++;
            if (trace[i] != want[i]) begin
                mismatched++; $display("FAIL backlog_trace_%0d: got %0d want %0d", i, trace[i], want[i]);
            end
        end
        compared++;
        if (data_seen !== 8'h69) begin mismatched++; $display("FAIL backlog_read_data: got %h want 69", data_seen); end
        bus_release();
        compared++;
        if (obs_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL backlog_cmd_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL backlog_cmd: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_refresh_saturate();
        bit bad, seen8;
        int maxp;
        obs_q.delete();
        hold_refresh = 1'b1;
        bad = 1'b0; seen8 = 1'b0; maxp = 0;
        for (int c = 0; c < 10 * RI; c++) begin
            @(negedge clock);
            if (int'(pif.refresh_pending) > maxp) maxp = int'(pif.refresh_pending);
            if (pif.refresh_pending > 4'd8 || (seen8 && pif.refresh_pending !== 4'd8)) bad = 1'b1;
            if (pif.refresh_pending === 4'd8) seen8 = 1'b1;
        end
        compared++;
        if (pif.refresh_pending !== 4'd8) begin
            mismatched++; $display("FAIL saturate_final: got %0d want 8", pif.refresh_pending);
        end
        compared++;
        if (bad) begin mismatched++; $display("FAIL saturate_hold: got max=%0d or wrap want steady 8", maxp); end
    endtask

    task automatic test_bus_abort();
        int n, nbus;
        bit bad;
        obs_q.delete();
        compared++;
        if ({pif.ctl_request, pif.ctl_refresh} !== 2'b11) begin
            mismatched++; $display("FAIL abort_refresh_busy: got %b%b want 11", pif.ctl_request, pif.ctl_refresh);
        end
        bus_drive(1'b0, 20'h0AAAA, 8'h00);
        #1;
        compared++;
        if (pif.memory_access_ready !== 1'b0) begin
            mismatched++; $display("FAIL abort_ready_low: got %b want 0", pif.memory_access_ready);
        end
        @(negedge clock);
        bus_release();
        hold_refresh = 1'b0;
        bad = 1'b0;
        n = 0;
        do begin
            #1;
            if (pif.memory_access_ready !== 1'b1) bad = 1'b1;
            @(negedge clock); n++;
        end while (!(pif.refresh_pending === 4'd0 && pif.ctl_request === 1'b0) && n < 300);
        repeat (4) @(negedge clock);
        nbus = 0;
        foreach (obs_q[i]) if (!obs_q[i][29]) nbus++;
        compared++;
        if (bad || n >= 300) begin mismatched++; $display("FAIL abort_ready_high: got wait/timeout want ready=1"); end
        compared++;
        if (nbus != 0) begin mismatched++; $display("FAIL abort_no_bus_cmd: got %0d want 0", nbus); end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_command();
        int n;
        logic [29:0] e, o;
        lat = 10;
        resp_data = 8'h77;
        bus_drive(1'b0, 20'h0F0F0, 8'h00);
        n = 0;
        do begin @(negedge clock); n++; end while (pif.ctl_request !== 1'b1 && n < 100);
        #2;
        reset_n = 1'b0;
        bus_release();
        #1;
        compared++;
        if (outputs_now() !== RESET_VEC || n >= 100) begin
            mismatched++; $display("FAIL async_reset: got %h want %h", outputs_now(), RESET_VEC);
        end
        @(negedge clock);
        reset_n = 1'b1;
        lat = 3;
        exp_q.delete(); obs_q.delete();
        @(negedge clock);
        bus_drive(1'b0, 20'h0F0F0, 8'h00);
        exp_q.push_back(pack_cmd(1'b0, 1'b0, 20'h0F0F0, 8'h00));
        n = 0;
        do begin @(negedge clock); n++; end while (pif.memory_access_ready !== 1'b1 && n < 100);
        compared++;
        if (pif.data_bus_out !== 8'h77 || n >= 100) begin
            mismatched++; $display("FAIL post_reset_read: got %h want 77", pif.data_bus_out);
        end
        bus_release();
        repeat (2) @(negedge clock);
        compared++;
        if (obs_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL post_reset_cmd_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL post_reset_cmd: got %h want %h", o, e); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        pif.address = '0;
        pif.internal_data_bus = '0;
        pif.memory_read_n = 1'b1;
        pif.memory_write_n = 1'b1;
        pif.ram_address_select_n = 1'b1;
        pif.video_request = 1'b0;
        pif.video_address = '0;
        test_reset();
        test_bus_read();
        test_round_robin();
        test_refresh_backlog();
        test_refresh_saturate();
        test_bus_abort();
        test_reset_mid_command();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
